// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin arbiter sharing one dpram port among NUM_REQ requesters.
// Optional owner lock enabled by defining DPRAM_ARB_LOCK_EN.
module dpram_port_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int ID_WIDTH      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
`ifdef DPRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                lock,
`endif
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]                gnt,
  output logic                              ram_we,
  output logic [ADDRESS_WIDTH-1:0]          ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_din,
  input  logic [DATA_WIDTH-1:0]             ram_dout,
  output logic                              rsp_valid,
  output logic [ID_WIDTH-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]             rsp_data
);
  localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [ID_WIDTH:0]   NR   = (ID_WIDTH+1)'(NUM_REQ);
  logic [2*NUM_REQ-1:0]     w_dbl;
  logic [ID_WIDTH-1:0]      w_off, w_rr_idx, w_gidx, w_ptr_nx;
  logic [ID_WIDTH:0]        w_sum;
  logic                     w_any, w_take, w_ptr_en;
  logic [ID_WIDTH-1:0]      r_ptr, r_id, r_rsp_id;
  logic                     r_ram_we, r_rd, r_rsp_valid;
  logic [ADDRESS_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0]    r_ram_din;
  // Rotate so bit 0 is the requester at the priority pointer; lowest set bit wins.
  assign w_dbl = {req, req} >> r_ptr;
  always_comb begin
    w_off = '0;
    w_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        w_off = ID_WIDTH'(i);
        w_any = 1'b1;
      end
    end
  end
  assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_rr_idx = (w_sum >= NR) ? ID_WIDTH'(w_sum - NR) : w_sum[ID_WIDTH-1:0];
`ifdef DPRAM_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t              r_state, w_state_nx;
  logic [ID_WIDTH-1:0] r_owner;
  assign w_gidx   = (r_state == LOCKED) ? r_owner : w_rr_idx;
  assign w_take   = ~rst & ((r_state == LOCKED) ? req[r_owner] : w_any);
  assign w_ptr_en = w_take | (r_state == LOCKED);
  always_comb begin
    w_state_nx = r_state;
    if (r_state == ARB)
      w_state_nx = (w_take && lock[w_gidx]) ? LOCKED : ARB;
    else if (!req[r_owner] || (w_take && !lock[r_owner]))
      w_state_nx = ARB;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == ARB && w_take) r_owner <= w_gidx;
    end
  end
`else
  assign w_gidx   = w_rr_idx;
  assign w_take   = ~rst & w_any;
  assign w_ptr_en = w_take;
`endif
  assign w_ptr_nx = (w_gidx == LAST) ? '0 : w_gidx + 1'b1;
  always_comb begin
    gnt = '0;
    if (w_take) gnt[w_gidx] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_rd        <= 1'b0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_ram_we    <= w_take & req_we[w_gidx];
      r_rd        <= w_take & ~req_we[w_gidx];
      r_rsp_valid <= r_rd;
      if (w_ptr_en) r_ptr <= w_ptr_nx;
      if (w_take) begin
        r_ram_addr <= req_addr[w_gidx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        r_ram_din  <= req_wdata[w_gidx*DATA_WIDTH +: DATA_WIDTH];
        r_id       <= w_gidx;
      end
      if (r_rd) r_rsp_id <= r_id;
    end
  end
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_valid ? ram_dout : '0;
endmodule
